pattern_writer: RTL and testbench
=================================

Name: pattern_writer

Overview:
- Write-side counterpart to the display read path of the PE array.
- Accepts a byte stream of row bitmaps on a valid/ready handshake and serialises it into one-cell-per-cycle write commands (cmd=2'b11, adr_x_i, adr_y_i, state_in) for pe_array.
- Replaces switch-driven single-cell writes.
- Places a full GRID_W x GRID_H pattern at a programmable origin, with toroidal wrap.

Parameters:
- GRID_W, 16, array width in cells; must be a multiple of 8.
- GRID_H, 16, array height in cells.
- AX_BITS, 4, x address width; must equal clog2(GRID_W).
- AY_BITS, 4, y address width; must equal clog2(GRID_H).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless IDLE.
- org_x  in  AX_BITS  x origin, sampled at start.
- org_y  in  AY_BITS  y origin, sampled at start.
- in_data  in  8  bitmap byte; bit0 = lowest x.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  writer will accept a byte this cycle.
- cmd  out  2  to pe_array: 2'b00 idle, 2'b11 write; never drives 2'b01.
- adr_x  out  AX_BITS  write x address.
- adr_y  out  AY_BITS  write y address.
- state  out  1  cell value to write.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse when the last cell has been written.
- err  out  1  checksum mismatch, sticky until next start (PATTERN_CHK_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, active-high) values: FSM=IDLE; cmd=2'b00; in_ready=0; busy=0; done=0; err=0; adr_x=0; adr_y=0; state=0; all counters 0.
- Reset asserted mid-load aborts immediately; cells already written stay written.
- FSM states: IDLE, WAIT_BYTE, WRITE, DONE.
- IDLE -> WAIT_BYTE on start. Latch org_x/org_y; clear row counter r, byte-in-row counter b and cell counter c.
- WAIT_BYTE: in_ready=1, cmd=00. On in_valid&in_ready, latch the byte into the shift register and go to WRITE.
  - Byte order: row-major. Row 0 first; within a row, byte 0 covers x offsets 0..7.
- WRITE: 8 cycles, c=0..7. Each cycle drives:
  - cmd=11
  - state=shreg[c]
  - adr_x=(org_x + 8*b + c) mod GRID_W
  - adr_y=(org_y + r) mod GRID_H
  - Modulo is natural truncation to the address width (power-of-2 grid).
  - in_ready=0 throughout.
- After c=7:
  - advance b; on b wrap (GRID_W/8 bytes), advance r.
  - If r and b are both at their last value, go to DONE; otherwise go to WAIT_BYTE.
- Latency: a byte accepted at cycle N produces cell writes at N+1..N+8. The earliest next acceptance is N+9.
- Peak throughput is 1 byte per 9 cycles; in_valid gaps simply stretch WAIT_BYTE.
- DONE: one cycle; done=1, cmd=00, busy still 1. Then go to IDLE.
- start while busy is ignored; it does not restart or re-latch the origin.
- start in the same cycle DONE exits is ignored; a new start is accepted only from IDLE.
- Zeros are written explicitly, so the load fully overwrites the target region.
- Outputs are registered: cmd/adr/state change only on clk edges.

Optional Feature:
- Macro: PATTERN_CHK_EN.
- Defined:
  - After the last data byte the FSM enters CHK (a 5th state) with in_ready=1 and accepts one extra byte.
  - That byte must equal the XOR of all data bytes. On mismatch err=1; err stays set until the next accepted start.
  - done pulses after CHK in either case.
  - cmd stays 00 in CHK.
- Undefined: no CHK state, err tied 0, and the stream is exactly GRID_W*GRID_H/8 bytes.

Decomposition:
- Package pattern_writer_pkg holds:
  - enum wr_state_t {IDLE, WAIT_BYTE, WRITE, DONE, CHK}
  - localparams CMD_IDLE=2'b00, CMD_STEP=2'b01, CMD_WRITE=2'b11, matching the pe_array command encoding.
- One sub-module, cell_serializer, holds the 8-bit shift register and the 3-bit cell counter.
  - Inputs: load, byte.
  - Outputs: bit, last.
- The top-level FSM owns the row/byte counters and address arithmetic.

Test Plan:
- Reset mid-WRITE (3rd cell of byte 5) -> all outputs return to reset values the same cycle. A subsequent start with in_data=8'hFF does a full load of 32 bytes.
- Origin 0, 32 bytes of 8'hA5, in_valid held high:
  - exactly 256 cmd=11 cycles; byte 0 writes x0..7 at y0 with states 1,0,1,0,0,1,0,1;
  - done pulses exactly once, 9*32+2 cycles after start.
- org_x=13, org_y=15, first byte 8'hFF -> writes (13,15),(14,15),(15,15),(0,15)..(4,15); the next row is y=0 (wrap).
- start pulsed during byte 10's WRITE -> no effect; load completes normally with the original origin, single done.
- in_valid toggled 1-of-3 cycles -> in_ready never high during WRITE; no byte lost or duplicated; the 256-write scoreboard matches.
- PATTERN_CHK_EN: correct XOR trailer -> err=0, done. Trailer XOR'd with 8'h01 -> err=1 until the next start.

Source files
------------

// File: rtl/pattern_writer_pkg.sv
// Shared types for pattern_writer: FSM state encoding and the pe_array command codes.
package pattern_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    WRITE,
    DONE,
    CHK
  } wr_state_t;

  // Must match the pe_array command decoder.
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

endpackage

// File: rtl/pattern_writer_cell_serializer.sv
// cell_serializer: holds one bitmap byte and presents it LSB-first, one cell per shift,
// with a 3-bit cell counter flagging the eighth cell.
module cell_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] byte_data,
  output logic       cell_bit,
  output logic       last
);

  logic [7:0] shreg;
  logic [2:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= byte_data;
      cnt   <= '0;
    end else if (shift) begin
      // Zero fill leaves the register clear (state output 0) once a byte is spent.
      shreg <= {1'b0, shreg[7:1]};
      cnt   <= cnt + 3'd1;
    end
  end

  assign cell_bit = shreg[0];
  assign last     = (cnt == 3'd7);

endmodule

// File: rtl/pattern_writer.sv
// pattern_writer: turns a row-major bitmap byte stream into one-cell-per-cycle pe_array
// writes at a latched origin with toroidal wrap. Define PATTERN_CHK_EN for the XOR trailer check.
module pattern_writer
  import pattern_writer_pkg::*;
#(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int AX_BITS = 4,
  parameter int AY_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AX_BITS-1:0] org_x,
  input  logic [AY_BITS-1:0] org_y,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         cmd,
  output logic [AX_BITS-1:0] adr_x,
  output logic [AY_BITS-1:0] adr_y,
  output logic               state,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int BPR = GRID_W / 8;
  localparam int BB  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [BB-1:0]      LAST_COL = BB'(BPR - 1);
  localparam logic [AY_BITS-1:0] LAST_ROW = AY_BITS'(GRID_H - 1);

  wr_state_t          fsm_q, fsm_d;
  logic [AX_BITS-1:0] org_x_q;
  logic [AY_BITS-1:0] org_y_q;
  logic [AY_BITS-1:0] row_q;
  logic [BB-1:0]      col_q;
  logic [AX_BITS-1:0] x_base;
  logic               accept, load_byte, start_ok, last_cell, last_byte;

  assign accept    = in_valid & in_ready;
  assign load_byte = accept & (fsm_q == WAIT_BYTE);
  assign start_ok  = start & (fsm_q == IDLE);
  assign last_byte = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign x_base    = org_x_q + AX_BITS'({col_q, 3'b000});

  cell_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load_byte),
    .shift     (fsm_q == WRITE),
    .byte_data (in_data),
    .cell_bit  (state),
    .last      (last_cell)
  );

  // NOTE: fsm_d gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:      if (start) fsm_d = WAIT_BYTE;
      WAIT_BYTE: if (accept) fsm_d = WRITE;
      WRITE: begin
        if (last_cell) begin
          if (!last_byte) fsm_d = WAIT_BYTE;
`ifdef PATTERN_CHK_EN
          else fsm_d = CHK;
`else
          else fsm_d = DONE;
`endif
        end
      end
`ifdef PATTERN_CHK_EN
      CHK:       if (accept) fsm_d = DONE;
`endif
      DONE:      fsm_d = IDLE;
      default:   fsm_d = IDLE;
    endcase
  end

  // Handshake and command outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      in_ready <= 1'b0;
      cmd      <= CMD_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      adr_x    <= '0;
      adr_y    <= '0;
      org_x_q  <= '0;
      org_y_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      in_ready <= (fsm_d == WAIT_BYTE) || (fsm_d == CHK);
      cmd      <= (fsm_d == WRITE) ? CMD_WRITE : CMD_IDLE;
      busy     <= (fsm_d != IDLE);
      done     <= (fsm_d == DONE);

      if (start_ok) begin
        org_x_q <= org_x;
        org_y_q <= org_y;
        row_q   <= '0;
        col_q   <= '0;
      end

      // Address width truncation provides the toroidal wrap.
      if (load_byte) begin
        adr_x <= x_base;
        adr_y <= org_y_q + row_q;
      end else if (fsm_q == WRITE) begin
        adr_x <= adr_x + AX_BITS'(1);
      end

      if (fsm_q == WRITE && last_cell) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + AY_BITS'(1);
        end else begin
          col_q <= col_q + BB'(1);
        end
      end
    end
  end

`ifdef PATTERN_CHK_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_q <= '0;
      err   <= 1'b0;
    end else if (start_ok) begin
      xor_q <= '0;
      err   <= 1'b0;
    end else if (load_byte) begin
      xor_q <= xor_q ^ in_data;
    end else if (accept && fsm_q == CHK) begin
      err <= (in_data != xor_q);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_writer.sv
// Self-checking bench for pattern_writer: directed loads with random data, compared
// against an arithmetic model of where each bitmap bit must land.
module tb_pattern_writer;
  import pattern_writer_pkg::*;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 16;
  localparam int AX_BITS = 4;
  localparam int AY_BITS = 4;
  localparam int NBYTES  = GRID_W * GRID_H / 8;
`ifdef PATTERN_CHK_EN
  localparam int CHK_CYC = 1;
`else
  localparam int CHK_CYC = 0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [AX_BITS-1:0] org_x;
  logic [AY_BITS-1:0] org_y;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         cmd;
  logic [AX_BITS-1:0] adr_x;
  logic [AY_BITS-1:0] adr_y;
  logic               state;
  logic               busy;
  logic               done;
  logic               err;

  pattern_writer #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .AX_BITS(AX_BITS),
    .AY_BITS(AY_BITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .org_x   (org_x),
    .org_y   (org_y),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cmd     (cmd),
    .adr_x   (adr_x),
    .adr_y   (adr_y),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] stream[$];
  int         exp_x[$];
  int         exp_y[$];
  logic       exp_s[$];

  int cyc_ctr = 0;
  int writes_seen = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int base = 0;
  int d0 = 0;
  int start_cyc = 0;
  int sent = 0;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_ctr++;

  // Write monitor: every cmd=11 cycle must match the next expected cell in order.
  always @(negedge clk) begin : monitor
    int idx;
    if (!reset) begin
      check("cmd_never_step", cmd == CMD_STEP, 1'b0);
      if (done) begin
        if (done_cnt == d0) done_cyc = cyc_ctr;
        done_cnt++;
      end
      if (cmd == CMD_WRITE) begin
        idx = writes_seen - base;
        check("in_ready_low_in_write", in_ready, 1'b0);
        check("write_in_range", idx < exp_x.size(), 1'b1);
        if (idx < exp_x.size()) begin
          check("adr_x", adr_x, exp_x[idx]);
          check("adr_y", adr_y, exp_y[idx]);
          check("cell_state", state, exp_s[idx]);
        end
        writes_seen++;
      end
    end
  end

  // kind: 0 random, 1 all A5, 2 all FF, 3 FF first then random.
  task automatic fill_stream(input int kind, input bit bad_trailer);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    for (int k = 0; k < NBYTES; k++) begin
      case (kind)
        1:       b = 8'hA5;
        2:       b = 8'hFF;
        3:       b = (k == 0) ? 8'hFF : 8'($urandom);
        default: b = 8'($urandom);
      endcase
      stream.push_back(b);
      x ^= b;
    end
`ifdef PATTERN_CHK_EN
    stream.push_back(bad_trailer ? (x ^ 8'h01) : x);
`else
    if (bad_trailer) x = 8'h00;
`endif
  endtask

  // Reference placement: byte k covers row k/(W/8), x offsets 8*(k%(W/8))+0..7.
  task automatic expect_load(input int ox, input int oy);
    exp_x.delete();
    exp_y.delete();
    exp_s.delete();
    for (int k = 0; k < NBYTES; k++) begin
      for (int c = 0; c < 8; c++) begin
        exp_x.push_back((ox + 8 * (k % (GRID_W / 8)) + c) % GRID_W);
        exp_y.push_back((oy + k / (GRID_W / 8)) % GRID_H);
        exp_s.push_back(stream[k][c]);
      end
    end
  endtask

  task automatic run_load(input int ox, input int oy, input bit gap, input int abort_at,
                          input int intr_byte, output bit was_aborted);
    int  cyc;
    bit  acc;
    bit  intr_pending;
    was_aborted  = 1'b0;
    intr_pending = (intr_byte >= 0);
    cyc  = 0;
    sent = 0;
    base = writes_seen;
    d0   = done_cnt;
    start     = 1'b1;
    org_x     = AX_BITS'(ox);
    org_y     = AY_BITS'(oy);
    start_cyc = cyc_ctr;
    @(posedge clk); #1;
    start = 1'b0;
    org_x = AX_BITS'(ox + 5);
    org_y = AY_BITS'(oy + 3);
    check("busy_after_start", busy, 1'b1);
    check("err_clear_after_start", err, 1'b0);
    while (sent < stream.size() && cyc < 4000) begin
      if (abort_at >= 0 && (writes_seen - base) == abort_at) begin
        was_aborted = 1'b1;
        in_valid = 1'b0;
        return;
      end
      if (intr_pending && sent == intr_byte + 1) begin
        start = 1'b1;
        org_x = AX_BITS'(ox + 7);
        org_y = AY_BITS'(oy + 9);
        intr_pending = 1'b0;
      end else begin
        start = 1'b0;
      end
      in_valid = gap ? ((cyc % 3) == 0) : 1'b1;
      in_data  = stream[sent];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("stream_accepted", sent, stream.size());
  endtask

  task automatic finish_load();
    int n;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done_cnt != d0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("write_count", writes_seen - base, exp_x.size());
    check("busy_low_after_done", busy, 1'b0);
    check("cmd_idle_after_done", cmd, CMD_IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"}, cmd, CMD_IDLE);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_adr_x"}, adr_x, 0);
    check({tag, "_adr_y"}, adr_y, 0);
    check({tag, "_state"}, state, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    org_x    = '0;
    org_y    = '0;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_values("reset");

    // Origin 0, all A5, in_valid held high: 256 writes and fixed done latency.
    fill_stream(1, 1'b0);
    expect_load(0, 0);
    run_load(0, 0, 1'b0, -1, -1, aborted);
    finish_load();
    // Counting the cycle start is high as cycle 1, done is high in cycle 9*N+2.
    check("done_latency", done_cyc - start_cyc + 1, 9 * NBYTES + 2 + CHK_CYC);

    // Origin (13,15) with first byte FF: x wraps 15->0 and the next row wraps to y=0.
    fill_stream(3, 1'b0);
    expect_load(13, 15);
    run_load(13, 15, 1'b0, -1, -1, aborted);
    finish_load();

    // start pulsed during byte 10's WRITE is ignored; origin stays as latched.
    fill_stream(0, 1'b0);
    expect_load(3, 5);
    run_load(3, 5, 1'b0, -1, 10, aborted);
    finish_load();

    // in_valid asserted one cycle in three.
    fill_stream(0, 1'b0);
    expect_load(6, 11);
    run_load(6, 11, 1'b1, -1, -1, aborted);
    finish_load();

    // start arriving while DONE is exiting must not begin a new load.
    fill_stream(0, 1'b0);
    expect_load(1, 2);
    run_load(1, 2, 1'b0, -1, -1, aborted);
    while (!done && cyc_ctr - start_cyc < 600) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("start_at_done_exit_ignored", busy, 1'b0);
    check("no_ready_after_ignored_start", in_ready, 1'b0);

    // Reset on the 3rd cell of byte 5 aborts at once; then a full FF load.
    fill_stream(0, 1'b0);
    expect_load(0, 0);
    run_load(0, 0, 1'b0, 5 * 8 + 2, -1, aborted);
    check("abort_point_reached", aborted, 1'b1);
    check("writing_before_reset", cmd, CMD_WRITE);
    reset = 1'b1;
    #1;
    check_reset_values("midload_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 1'b0);
    fill_stream(2, 1'b0);
    expect_load(2, 9);
    run_load(2, 9, 1'b0, -1, -1, aborted);
    finish_load();

`ifdef PATTERN_CHK_EN
    // Correct trailer keeps err low; a corrupted one sets err until the next start.
    fill_stream(0, 1'b0);
    expect_load(4, 4);
    run_load(4, 4, 1'b0, -1, -1, aborted);
    finish_load();
    check("chk_good_err", err, 1'b0);
    fill_stream(0, 1'b1);
    expect_load(8, 1);
    run_load(8, 1, 1'b0, -1, -1, aborted);
    finish_load();
    check("chk_bad_err", err, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("chk_err_sticky", err, 1'b1);
    fill_stream(0, 1'b0);
    expect_load(0, 0);
    run_load(0, 0, 1'b0, -1, -1, aborted);
    finish_load();
    check("chk_err_after_clean_load", err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
